// File: rtl/tt_sweep.sv
// tt_sweep: exhaustive truth-table sweeper for a single-output combinational function.
//
// Drives every input pattern 0 .. 2^NIN-1 on x_out, samples the function output y_in
// for each one, packs the samples into WORD_W-bit result words and hands them out on a
// valid/ready stream. It also keeps a count of ones and a 16-bit MISR signature of the
// sample stream.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      sweep request, sampled only while idle
//   x_out      registered input pattern to the function (x_out[i] drives xi)
//   y_in       function output for the pattern on x_out (0-latency)
//   busy       high while sweeping or draining the final word
//   done       one-cycle completion pulse
//   res_valid  result word available
//   res_ready  consumer accepts the word at a clock edge when res_valid is high
//   res_data   packed samples; bit j is pattern res_addr*WORD_W+j
//   res_addr   word index
//   ones_cnt   number of samples with y_in=1
//   signature  MISR over the sample stream (polynomial 0x1021)
module tt_sweep #(
  parameter int unsigned NIN    = 10,
  parameter int unsigned WORD_W = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic [NIN-1:0]                    x_out,
  input  logic                              y_in,
  output logic                              busy,
  output logic                              done,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [WORD_W-1:0]                 res_data,
  output logic [NIN-$clog2(WORD_W)-1:0]     res_addr,
  output logic [NIN:0]                      ones_cnt,
  output logic [15:0]                       signature
);

  localparam int unsigned LW = $clog2(WORD_W);

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

  state_e              state_q;
  logic [WORD_W-1:0]   pack_q;

  logic                stall;
  logic                word_end;
  logic                last_pat;
  logic                fb;
  logic [15:0]         sig_next;

  // A pending word the consumer is not taking freezes the whole sweep.
  assign stall    = res_valid & ~res_ready;
  assign word_end = &x_out[LW-1:0];
  assign last_pat = &x_out;
  assign fb       = signature[15] ^ y_in;
  assign sig_next = {signature[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_addr  <= '0;
      ones_cnt  <= '0;
      signature <= 16'h0000;
      pack_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StSweep;
            busy      <= 1'b1;
            x_out     <= '0;
            ones_cnt  <= '0;
            signature <= 16'hFFFF;
            pack_q    <= '0;
          end
        end

        StSweep: begin
          if (!stall) begin
            pack_q[x_out[LW-1:0]] <= y_in;
            ones_cnt              <= ones_cnt + {{NIN{1'b0}}, y_in};
            signature             <= sig_next;
            if (word_end) begin
              // Completed word includes this cycle's sample in its top bit. Any older
              // word is being handshaken at this same edge, since we are not stalled.
              res_valid <= 1'b1;
              res_data  <= {y_in, pack_q[WORD_W-2:0]};
              res_addr  <= x_out[NIN-1:LW];
            end else if (res_valid) begin
              res_valid <= 1'b0;
            end
            if (last_pat) begin
              state_q <= StDrain;
            end else begin
              x_out <= x_out + NIN'(1);
            end
          end
        end

        StDrain: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= StDone;
          end
        end

        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep.sv
// Directed self-checking bench for tt_sweep (NIN=10, WORD_W=32).
module tb_tt_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        res_ready = 1'b1;
  logic [9:0]  x_out;
  logic        y_in;
  logic        busy;
  logic        done;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_addr;
  logic [10:0] ones_cnt;
  logic [15:0] signature;

  int n_chk = 0;
  int n_pass = 0;
  int mode = 0;

  logic [31:0] got [32];
  int          got_n [32];

  always #5 clk = ~clk;

  // Function under test selected by mode: 0 -> 0, 1 -> 1, 2 -> x0, 3 -> x5.
  assign y_in = (mode == 1) ? 1'b1 : (mode == 2) ? x_out[0] : (mode == 3) ? x_out[5] : 1'b0;

  tt_sweep #(.NIN(10), .WORD_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_out     (x_out),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_addr  (res_addr),
    .ones_cnt  (ones_cnt),
    .signature (signature)
  );

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic fmodel(input int md, input int k);
    logic [9:0] kv;
    kv = k[9:0];
    case (md)
      1:       return 1'b1;
      2:       return kv[0];
      3:       return kv[5];
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_sweep(input int md, input bit stall_en, input bit start_during,
                           input int exp_cyc);
    int          cyc;
    int          stall_left;
    bit          seen_done;
    logic [9:0]  fx;
    logic [31:0] fd;
    logic [31:0] ew;
    int          eones;
    logic [15:0] esig;
    logic        fb;
    mode = md;
    for (int a = 0; a < 32; a++) begin
      got[a]   = '0;
      got_n[a] = 0;
    end
    stall_left = stall_en ? 10 : 0;
    fx = '0;
    fd = '0;
    @(negedge clk);
    start     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc       = 0;
    seen_done = 1'b0;
    while (cyc < 3000 && !seen_done) begin
      @(negedge clk);
      cyc++;
      start = start_during && (cyc == 300 || cyc == 1025);
      if (stall_en && res_valid && res_addr == 5'd3 && stall_left > 0) begin
        if (stall_left == 10) begin
          fx = x_out;
          fd = res_data;
        end else begin
          check("stall_x", x_out, fx);
          check("stall_data", res_data, fd);
        end
        stall_left--;
        res_ready = 1'b0;
      end else begin
        res_ready = 1'b1;
      end
      if (cyc == 1) begin
        check("busy_c1", busy, 1);
        check("x_c1", x_out, 0);
      end
      if (!stall_en && cyc == 1025) begin
        check("drain_x", x_out, 10'd1023);
        check("drain_busy", busy, 1);
      end
      if (res_valid && res_ready) begin
        got[res_addr] = res_data;
        got_n[res_addr]++;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", cyc, exp_cyc);
      end
    end
    start     = 1'b0;
    res_ready = 1'b1;
    check("done_seen", seen_done, 1);

    eones = 0;
    esig  = 16'hFFFF;
    for (int a = 0; a < 32; a++) begin
      for (int j = 0; j < 32; j++) ew[j] = fmodel(md, a * 32 + j);
      check($sformatf("word%0d", a), got[a], ew);
      check($sformatf("wcnt%0d", a), got_n[a], 1);
    end
    for (int k = 0; k < 1024; k++) begin
      eones += int'(fmodel(md, k));
      fb   = esig[15] ^ fmodel(md, k);
      esig = {esig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end

    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", res_valid, 0);
    check("ones", ones_cnt, eones);
    check("sig", signature, esig);
    repeat (3) @(negedge clk);
    check("ones_hold", ones_cnt, eones);
    check("sig_hold", signature, esig);
    check("stay_idle", busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, x_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_data"}, res_data, 0);
    check({tag, "_addr"}, res_addr, 0);
    check({tag, "_ones"}, ones_cnt, 0);
    check({tag, "_sig"}, signature, 16'h0000);
  endtask

  initial begin
    int  waits;
    #12;
    check_reset_vals("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_auto_start", busy, 0);

    run_sweep(0, 1'b0, 1'b0, 1026);
    run_sweep(1, 1'b0, 1'b0, 1026);
    run_sweep(2, 1'b0, 1'b1, 1026);
    run_sweep(3, 1'b1, 1'b0, 1036);

    // Asynchronous reset in the middle of a sweep.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waits = 0;
    while (x_out != 10'd500 && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    check("reach_500", x_out, 10'd500);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_x", x_out, 0);

    run_sweep(3, 1'b0, 1'b0, 1026);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
